// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
// Holds FSM states, RV32 funct3 encodings, lane-mask/replication helpers and counter sizing.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wide enough to hold TIMEOUT-1; never narrower than one bit.
  function automatic int timeout_cnt_w(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic logic [3:0] mask_from_size(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 4'b0001 << offset;
      SZ_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_legal(input logic store, input logic [2:0] funct3);
    if (store) begin
      return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end
    return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundles for the LSU: core-side op/response channel and memory-side request channel.
// In both, master is the side that issues requests.
interface lsu_core_if;
  logic        op_valid;
  logic        op_ready;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output op_valid, op_store, op_funct3, op_addr, op_wdata,
    input  op_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  op_valid, op_store, op_funct3, op_addr, op_wdata,
    output op_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 8);
  logic              mem_request;
  logic              mem_we_re;
  logic              mem_load;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_valid;
  logic [31:0]       mem_data_out;

  modport master (
    output mem_request, mem_we_re, mem_load, mem_mask, mem_address, mem_data_in,
    input  mem_valid, mem_data_out
  );

  modport slave (
    input  mem_request, mem_we_re, mem_load, mem_mask, mem_address, mem_data_in,
    output mem_valid, mem_data_out
  );
endinterface

// File: rtl/lsu_mem_ctrl_load_ext.sv
// Load result formatter: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it (funct3[2] selects unsigned).
module lsu_load_ext (
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  import lsu_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  // Halves only look at offset[1], so misaligned halves are force-aligned here.
  always_comb begin
    w_byte   = i_word[{i_offset, 3'b000} +: 8];
    w_half   = i_offset[1] ? i_word[31:16] : i_word[15:0];
    w_signed = ~i_funct3[2];
    o_data   = i_word;
    case (i_funct3[1:0])
      SZ_BYTE: o_data = {{24{w_byte[7] & w_signed}}, w_byte};
      SZ_HALF: o_data = {{16{w_half[15] & w_signed}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the execute stage and data memory; one response per op.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halves/words are rejected with err instead of force-aligned.
module lsu_mem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4
) (
  input logic        clk,
  input logic        rst,
  lsu_core_if.slave  core,
  lsu_mem_if.master  mem
);
  import lsu_pkg::*;

  localparam int              CNT_W    = timeout_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [31:0]       w_rdata_next;
  logic              r_err;
  logic              w_err_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [31:0]       w_ext_data;
  logic              w_reject;

  lsu_load_ext u_load_ext (
    .i_word   (mem.mem_data_out),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ext_data)
  );

  always_comb begin
    w_reject = ~is_legal(core.op_store, core.op_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    w_reject = w_reject | is_misaligned(core.op_funct3[1:0], core.op_addr[1:0]);
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_rdata_next = r_rdata;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (core.op_valid) begin
          w_err_next   = w_reject;
          w_rdata_next = '0;
          w_cnt_next   = '0;
          w_state_next = w_reject ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        w_cnt_next   = '0;
        w_state_next = r_store ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_valid) begin
          w_rdata_next = w_ext_data;
          w_state_next = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_err_next   = 1'b1;
          w_rdata_next = '0;
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      r_rdata <= w_rdata_next;
      r_err   <= w_err_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && core.op_valid) begin
        r_store  <= core.op_store;
        r_funct3 <= core.op_funct3;
        r_addr   <= core.op_addr[ADDR_W+1:0];
        r_wdata  <= core.op_wdata;
      end
    end
  end

  // Outputs decode only registered state and latched op fields.
  always_comb begin
    core.op_ready   = 1'b0;
    core.rsp_valid  = 1'b0;
    core.rsp_rdata  = '0;
    core.rsp_err    = 1'b0;
    mem.mem_request = 1'b0;
    mem.mem_we_re   = 1'b0;
    mem.mem_load    = 1'b0;
    mem.mem_mask    = '0;
    mem.mem_address = '0;
    mem.mem_data_in = '0;
    case (r_state)
      S_IDLE: core.op_ready = 1'b1;
      S_REQ: begin
        mem.mem_request = 1'b1;
        mem.mem_we_re   = r_store;
        mem.mem_load    = ~r_store;
        mem.mem_mask    = mask_from_size(r_funct3[1:0], r_addr[1:0]);
        mem.mem_address = r_addr[ADDR_W+1:2];
        mem.mem_data_in = replicate_wdata(r_funct3[1:0], r_wdata);
      end
      S_RESP: begin
        core.rsp_valid = 1'b1;
        core.rsp_rdata = r_rdata;
        core.rsp_err   = r_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed vector table, reset-in-WAIT sequence and
// randomized ops against a byte-level memory model (honours LSU_MISALIGN_TRAP_EN).
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;
  localparam int NO_RESP = -1;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          cycle;
    int          reqCount;
    logic [3:0]  mask;
    logic [7:0]  maddr;
    logic [31:0] mdata;
  } expT;

  typedef struct {
    bit          store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memWord;
    int          latency;
    expT         exp;
  } vecT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lsu_core_if core ();
  lsu_mem_if #(.ADDR_W(ADDR_W)) mem ();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core),
    .mem  (mem)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] physMem [256];
  logic [31:0] refMem  [256];
  int          respLatency = 0;
  int          pendCnt = 0;
  logic [ADDR_W-1:0] pendAddr = '0;
  vecT         vecs[$];

  int          obsCycle, obsReqCount, obsPulses;
  logic        obsErr, obsWe, obsLoad;
  logic        obsReadyAtAccept, obsReadyInResp, obsReadyAfter;
  logic [31:0] obsRdata, obsData;
  logic [3:0]  obsMask;
  logic [ADDR_W-1:0] obsAddr;

  // Memory responder: writes lanes on store strobes, returns read data after 1+latency cycles.
  always @(negedge clk) begin
    mem.mem_valid    = 1'b0;
    mem.mem_data_out = '0;
    if (pendCnt > 0) begin
      pendCnt--;
      if (pendCnt == 0) begin
        mem.mem_valid    = 1'b1;
        mem.mem_data_out = physMem[pendAddr];
      end
    end
    if (mem.mem_request === 1'b1 && mem.mem_we_re === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (mem.mem_mask[i]) physMem[mem.mem_address][8*i +: 8] = mem.mem_data_in[8*i +: 8];
      end
    end
    if (mem.mem_request === 1'b1 && mem.mem_load === 1'b1 && respLatency >= 0) begin
      pendCnt  = respLatency + 1;
      pendAddr = mem.mem_address;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Byte-addressed model of one op; updates refMem for stores.
  task automatic modelOp(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, output expT e);
    bit     legal;
    bit     trap;
    int     nBytes, off, idx;
    longint val;
    e.err = 1'b0; e.rdata = '0; e.cycle = 0; e.reqCount = 0;
    e.mask = '0; e.maddr = '0; e.mdata = '0;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nBytes = 1 << f3[1:0];
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = legal && ((int'(addr[1:0]) % nBytes) != 0);
`endif
    if (!legal || trap) begin
      e.err = 1'b1;
      e.cycle = 1;
      return;
    end
    off = int'(addr[1:0]) - (int'(addr[1:0]) % nBytes);
    idx = int'(addr[ADDR_W+1:2]);
    e.reqCount = 1;
    e.maddr = addr[ADDR_W+1:2];
    for (int i = 0; i < 4; i++) begin
      e.mask[i] = (i >= off) && (i < off + nBytes);
      e.mdata[8*i +: 8] = wdata[8*(i % nBytes) +: 8];
    end
    if (st) begin
      for (int k = 0; k < nBytes; k++) refMem[idx][8*(off+k) +: 8] = wdata[8*k +: 8];
      e.cycle = 2;
    end else if (lat < 0 || lat >= TIMEOUT) begin
      e.err = 1'b1;
      e.cycle = 2 + TIMEOUT;
    end else begin
      val = 0;
      for (int k = 0; k < nBytes; k++) val = val | (longint'(refMem[idx][8*(off+k) +: 8]) << (8*k));
      if (!f3[2] && nBytes < 4 && val >= (longint'(1) << (8*nBytes - 1))) val = val - (longint'(1) << (8*nBytes));
      e.rdata = val[31:0];
      e.cycle = 3 + lat;
    end
  endtask

  // Issues one op and records what the DUT did until one cycle after its response.
  task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int lat);
    bit done;
    respLatency = lat;
    @(negedge clk);
    core.op_valid  = 1'b1;
    core.op_store  = st;
    core.op_funct3 = f3;
    core.op_addr   = addr;
    core.op_wdata  = wdata;
    obsReadyAtAccept = core.op_ready;
    @(posedge clk);
    #1;
    core.op_valid = 1'b0;
    obsCycle = -1; obsReqCount = 0; obsPulses = 0;
    obsErr = 1'b0; obsWe = 1'b0; obsLoad = 1'b0; obsRdata = '0; obsData = '0;
    obsMask = '0; obsAddr = '0; obsReadyInResp = 1'b1; obsReadyAfter = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (mem.mem_request === 1'b1) begin
        obsReqCount++;
        obsMask = mem.mem_mask; obsAddr = mem.mem_address; obsData = mem.mem_data_in;
        obsWe = mem.mem_we_re; obsLoad = mem.mem_load;
      end
      if (core.rsp_valid === 1'b1) begin
        obsPulses++;
        if (obsCycle < 0) begin
          obsCycle = c; obsRdata = core.rsp_rdata; obsErr = core.rsp_err;
          obsReadyInResp = core.op_ready;
        end
      end else if (obsCycle >= 0) begin
        obsReadyAfter = core.op_ready;
        done = 1'b1;
      end
    end
  endtask

  task automatic checkOp(input string tag, input bit st, input expT e);
    checkOutput({tag, " readyAtAccept"}, 32'(obsReadyAtAccept), 32'd1);
    checkOutput({tag, " rspCycle"}, 32'(obsCycle), 32'(e.cycle));
    checkOutput({tag, " err"}, 32'(obsErr), 32'(e.err));
    checkOutput({tag, " rdata"}, obsRdata, e.rdata);
    checkOutput({tag, " rspPulses"}, 32'(obsPulses), 32'd1);
    checkOutput({tag, " reqCount"}, 32'(obsReqCount), 32'(e.reqCount));
    checkOutput({tag, " readyInResp"}, 32'(obsReadyInResp), 32'd0);
    checkOutput({tag, " readyAfter"}, 32'(obsReadyAfter), 32'd1);
    if (e.reqCount > 0) begin
      checkOutput({tag, " mask"}, 32'(obsMask), 32'(e.mask));
      checkOutput({tag, " address"}, 32'(obsAddr), 32'(e.maddr));
      checkOutput({tag, " weRe"}, 32'(obsWe), 32'(st));
      checkOutput({tag, " load"}, 32'(obsLoad), 32'(!st));
      if (st) checkOutput({tag, " dataIn"}, obsData, e.mdata);
    end
  endtask

  task automatic addVec(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] memWord, input int lat,
                        input bit err, input logic [31:0] rdata, input int cyc, input int reqs,
                        input logic [3:0] mask, input logic [7:0] maddr, input logic [31:0] mdata);
    vecT v;
    v.store = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.memWord = memWord; v.latency = lat;
    v.exp.err = err; v.exp.rdata = rdata; v.exp.cycle = cyc; v.exp.reqCount = reqs;
    v.exp.mask = mask; v.exp.maddr = maddr; v.exp.mdata = mdata;
    vecs.push_back(v);
  endtask

  initial begin
    expT         e;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          lat;
    int          pulses;
    logic [2:0]  loadF3 [5];
    loadF3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

    core.op_valid = 1'b0; core.op_store = 1'b0; core.op_funct3 = '0;
    core.op_addr = '0; core.op_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      physMem[i] = $urandom;
      refMem[i]  = physMem[i];
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset op_ready", 32'(core.op_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(core.rsp_valid), 32'd0);
    checkOutput("reset rsp_rdata", core.rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", 32'(core.rsp_err), 32'd0);
    checkOutput("reset mem_request", 32'(mem.mem_request), 32'd0);
    checkOutput("reset mem_we_re", 32'(mem.mem_we_re), 32'd0);
    checkOutput("reset mem_load", 32'(mem.mem_load), 32'd0);
    checkOutput("reset mem_mask", 32'(mem.mem_mask), 32'd0);
    checkOutput("reset mem_address", 32'(mem.mem_address), 32'd0);
    checkOutput("reset mem_data_in", mem.mem_data_in, 32'd0);
    rst = 1'b0;

    //     st f3      addr          wdata         memWord       lat      err rdata         cyc rq mask     maddr  mdata
    addVec(1, F3_SW,  32'h0000_0010, 32'hDEADBEEF, 32'h0,        0,       0, 32'h0,        2, 1, 4'b1111, 8'h04, 32'hDEADBEEF);
    addVec(1, F3_SB,  32'h0000_0013, 32'h0000_00A5, 32'h0,       0,       0, 32'h0,        2, 1, 4'b1000, 8'h04, 32'hA5A5A5A5);
    addVec(1, F3_SH,  32'h0000_0016, 32'h1234_BEEF, 32'h0,       0,       0, 32'h0,        2, 1, 4'b1100, 8'h05, 32'hBEEFBEEF);
    addVec(0, F3_LB,  32'h0000_0013, 32'h0,        32'h80FF7F01, 0,       0, 32'hFFFFFF80, 3, 1, 4'b1000, 8'h04, 32'h0);
    addVec(0, F3_LBU, 32'h0000_0013, 32'h0,        32'h80FF7F01, 0,       0, 32'h00000080, 3, 1, 4'b1000, 8'h04, 32'h0);
    addVec(0, F3_LH,  32'h0000_0012, 32'h0,        32'h80FF7F01, 0,       0, 32'hFFFF80FF, 3, 1, 4'b1100, 8'h04, 32'h0);
    addVec(0, F3_LHU, 32'h0000_0012, 32'h0,        32'h80FF7F01, 0,       0, 32'h000080FF, 3, 1, 4'b1100, 8'h04, 32'h0);
    addVec(0, F3_LW,  32'h0000_0010, 32'h0,        32'h80FF7F01, 0,       0, 32'h80FF7F01, 3, 1, 4'b1111, 8'h04, 32'h0);
    addVec(0, F3_LB,  32'h0000_0010, 32'h0,        32'h80FF7F01, 0,       0, 32'h00000001, 3, 1, 4'b0001, 8'h04, 32'h0);
    addVec(0, F3_LB,  32'h0000_0011, 32'h0,        32'h80FF7F01, 0,       0, 32'h0000007F, 3, 1, 4'b0010, 8'h04, 32'h0);
    addVec(0, F3_LB,  32'h0000_0012, 32'h0,        32'h80FF7F01, 0,       0, 32'hFFFFFFFF, 3, 1, 4'b0100, 8'h04, 32'h0);
    addVec(0, F3_LW,  32'h0000_0020, 32'h0,        32'h11223344, NO_RESP, 1, 32'h0,        6, 1, 4'b1111, 8'h08, 32'h0);
    addVec(0, F3_LH,  32'h0000_0020, 32'h0,        32'h00008001, 3,       0, 32'hFFFF8001, 6, 1, 4'b0011, 8'h08, 32'h0);
    addVec(0, F3_LH,  32'h0000_0020, 32'h0,        32'h00008001, 4,       1, 32'h0,        6, 1, 4'b0011, 8'h08, 32'h0);
    addVec(0, 3'b011, 32'h0000_0010, 32'h0,        32'h12345678, 0,       1, 32'h0,        1, 0, 4'b0000, 8'h00, 32'h0);
    addVec(0, 3'b110, 32'h0000_0010, 32'h0,        32'h12345678, 0,       1, 32'h0,        1, 0, 4'b0000, 8'h00, 32'h0);
    addVec(1, 3'b100, 32'h0000_0010, 32'h5555AAAA, 32'h0,        0,       1, 32'h0,        1, 0, 4'b0000, 8'h00, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    addVec(0, F3_LW,  32'h0000_0011, 32'h0,        32'h12345678, 0,       1, 32'h0,        1, 0, 4'b0000, 8'h00, 32'h0);
    addVec(1, F3_SH,  32'h0000_0015, 32'h0000CAFE, 32'h0,        0,       1, 32'h0,        1, 0, 4'b0000, 8'h00, 32'h0);
    addVec(0, F3_LHU, 32'h0000_0013, 32'h0,        32'hAABBCCDD, 0,       1, 32'h0,        1, 0, 4'b0000, 8'h00, 32'h0);
`else
    addVec(0, F3_LW,  32'h0000_0011, 32'h0,        32'h12345678, 0,       0, 32'h12345678, 3, 1, 4'b1111, 8'h04, 32'h0);
    addVec(1, F3_SH,  32'h0000_0015, 32'h0000CAFE, 32'h0,        0,       0, 32'h0,        2, 1, 4'b0011, 8'h05, 32'hCAFECAFE);
    addVec(0, F3_LHU, 32'h0000_0013, 32'h0,        32'hAABBCCDD, 0,       0, 32'h0000AABB, 3, 1, 4'b1100, 8'h04, 32'h0);
`endif

    foreach (vecs[n]) begin
      if (!vecs[n].store) begin
        physMem[vecs[n].addr[ADDR_W+1:2]] = vecs[n].memWord;
        refMem[vecs[n].addr[ADDR_W+1:2]]  = vecs[n].memWord;
      end
      modelOp(vecs[n].store, vecs[n].f3, vecs[n].addr, vecs[n].wdata, vecs[n].latency, e);
      applyStimulus(vecs[n].store, vecs[n].f3, vecs[n].addr, vecs[n].wdata, vecs[n].latency);
      checkOp($sformatf("vec%0d", n), vecs[n].store, vecs[n].exp);
    end

    // Reset while waiting on a load; the late mem_valid lands in IDLE and must be ignored.
    respLatency = 1;
    @(negedge clk);
    core.op_valid = 1'b1; core.op_store = 1'b0; core.op_funct3 = F3_LW;
    core.op_addr = 32'h0000_000C; core.op_wdata = '0;
    @(posedge clk);
    #1;
    core.op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstWait busy", 32'(core.op_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstWait op_ready", 32'(core.op_ready), 32'd1);
    checkOutput("rstWait rsp_valid", 32'(core.rsp_valid), 32'd0);
    checkOutput("rstWait rsp_err", 32'(core.rsp_err), 32'd0);
    checkOutput("rstWait rsp_rdata", core.rsp_rdata, 32'd0);
    checkOutput("rstWait mem_request", 32'(mem.mem_request), 32'd0);
    checkOutput("rstWait mem_mask", 32'(mem.mem_mask), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (core.rsp_valid === 1'b1) pulses++;
    end
    checkOutput("rstWait noRsp", 32'(pulses), 32'd0);

    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = loadF3[$urandom_range(0, 4)];
      addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      lat = ($urandom_range(0, 9) == 0) ? NO_RESP : int'($urandom_range(0, TIMEOUT + 1));
      modelOp(st, f3, addr, physMem[0], lat, e);
      applyStimulus(st, f3, addr, physMem[0], lat);
      checkOp($sformatf("rnd%0d", n), st, e);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator that sits between the core execute stage and the data memory responder. It accepts one load or store op from the core and drives the memory's request, write-enable, load, mask, address and data lines. For loads it waits for the memory's one-cycle-delayed valid, then extracts and sign- or zero-extends the result. It returns exactly one response pulse per accepted op.

Parameters:
ADDR_W, 8, width of the word address driven to memory (word index = op_addr[ADDR_W+1:2])
TIMEOUT, 4, maximum WAIT cycles before a load is aborted with err=1; legal range 1..255

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
op_valid  in  1  core op present
op_ready  out  1  block can accept an op (high only in IDLE)
op_store  in  1  1 = store, 0 = load
op_funct3  in  3  RV32 funct3 (size in [1:0], unsigned-load flag in [2])
op_addr  in  32  byte address
op_wdata  in  32  store data (LSBs significant)
rsp_valid  out  1  single-cycle completion pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  illegal funct3, timeout, or trapped misalignment
mem_request  out  1  memory access strobe
mem_we_re  out  1  1 = write, 0 = read
mem_load  out  1  read request; memory returns valid one cycle later
mem_mask  out  4  byte-lane enables
mem_address  out  ADDR_W  word address
mem_data_in  out  32  lane-replicated write data
mem_valid  in  1  memory read data valid
mem_data_out  in  32  memory read word

Behaviour:
- Reset: state IDLE. All outputs 0 except op_ready=1. Counter cleared.
- Reset mid-operation: abort to IDLE at the next edge. No rsp_valid. A mem_valid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: op_ready=1. On op_valid, latch op_store, op_funct3, op_addr and op_wdata.
  - Illegal funct3 goes to RESP with err=1. Illegal for loads: 011, 110, 111. Illegal for stores: anything other than 000, 001, 010.
  - Otherwise go to REQ.
- REQ (exactly one cycle):
  - mem_request=1; mem_we_re=op_store; mem_load=!op_store.
  - Mask: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - Write data: byte replicated 4x, half replicated 2x, word as-is.
  - Store goes to RESP. Load goes to WAIT with counter=0.
- WAIT: all mem_* outputs 0.
  - On mem_valid: capture mem_data_out. Select the lane(s) using the address offset. Sign-extend if funct3[2]=0, zero-extend if funct3[2]=1. Go to RESP.
  - Else increment counter. When counter reaches TIMEOUT-1 without mem_valid, go to RESP with err=1 and rdata=0.
- RESP (one cycle): rsp_valid=1 with rdata and err held. Go to IDLE. op_ready=0 in this state, so back-to-back ops are spaced one IDLE cycle apart.
- Latency from the acceptance edge to the rsp_valid cycle:
  - Store: 2 cycles.
  - Load: 3 cycles with a nominal memory.
  - Error: 1 cycle.
- rsp_valid has no backpressure. The core must sample it in the cycle it is high.
- Outputs are registered from state/latched values; there is no combinational path from op_* to mem_*.

Optional Feature:
Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) never reaches memory. It goes IDLE→RESP with err=1 and rdata=0.
- Undefined: misaligned offsets are force-aligned (half uses addr[1] only, word uses offset 0), the access proceeds normally, and err=0.

Decomposition:
- Package lsu_pkg holds:
  - state enum;
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - mask_from_size function;
  - TIMEOUT counter width derivation.
- One sub-module, lsu_load_ext: combinational lane select plus sign/zero extension (inputs: word, offset, funct3; output: 32-bit value).

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF → REQ cycle shows mask 1111, address 0x04, we_re=1, data 0xDEADBEEF; rsp_valid 2 cycles after accept, err=0.
- SB addr 0x13, data 0x000000A5 → mask 1000, mem_data_in 0xA5A5A5A5, address 0x04.
- LB addr 0x13 with memory word 0x80FF7F01 → rdata 0xFFFFFF80. LBU → 0x00000080. LH addr 0x12 → 0xFFFF80FF. All arrive 3 cycles after accept.
- Load where mem_valid is held low → after TIMEOUT=4 WAIT cycles, rsp_valid=1, err=1, rdata=0; op_ready returns the next cycle.
- op_funct3=011 load, and a misaligned LW at 0x11 with the macro defined → no mem_request pulse; rsp_valid with err=1 one cycle after accept. Without the macro, the LW at 0x11 reads word 0x04 with err=0.
- rst asserted while in WAIT, then mem_valid pulses → no rsp_valid; outputs 0 and op_ready=1 the cycle after the reset edge.
